// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: owns the PC, presents it to the instruction
// memory, captures the returned word into a valid/ready output slot, and
// stops fetching after capturing the halt word until execute redirects it.
//
// state  | meaning
// S_RUN  | fetching; a capture happens whenever enabled and the slot is free
// S_HALT | halt word captured; PC frozen, slot drains, waits for a redirect
module fetch_unit #(
    parameter int                ADDR_W    = 5,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [DATA_W-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [ADDR_W-1:0] adressIM,
    input  logic [DATA_W-1:0] inst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic              halted
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] opc_q, opc_d;

    logic slot_free;
    logic xfer;
    logic fire;

    // Acceptance by decode frees the slot in the same cycle, so a stalled
    // stream restarts without a bubble the moment out_ready rises.
    assign slot_free = !valid_q || out_ready;
    assign xfer      = valid_q && out_ready;
    assign fire      = en && (state_q == S_RUN) && !redirect_valid && slot_free;

    // Next-state: redirect beats everything (flushes the slot even if it is
    // being accepted), then a new capture, then a plain drain.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        inst_d  = inst_q;
        opc_d   = opc_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
            state_d = S_RUN;
        end else if (fire) begin
            inst_d  = inst;
            opc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + PC_ONE;
            if (inst == HALT_WORD) begin
                state_d = S_HALT;
            end
        end else if (xfer) begin
            valid_d = 1'b0;
        end
    end

    // State, PC and output slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            inst_q  <= '0;
            opc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            inst_q  <= inst_d;
            opc_q   <= opc_d;
        end
    end

    assign adressIM  = pc_q;
    assign out_valid = valid_q;
    assign out_inst  = inst_q;
    assign out_pc    = opc_q;
    assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational instruction memory model.
module tb_fetch_unit;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [4:0]  adressIM;
    logic [31:0] inst;
    logic        redirect_valid;
    logic [4:0]  redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [4:0]  out_pc;
    logic        halted;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .adressIM       (adressIM),
        .inst           (inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .halted         (halted)
    );

    // Memory model: word = address, except address 6 holds the halt word.
    assign inst = (adressIM == 5'd6) ? HALT : {27'h0, adressIM};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_slot(input string tag, input logic [4:0] pc);
        check({tag, "_valid"}, {31'h0, out_valid}, 32'd1);
        check({tag, "_pc"}, {27'h0, out_pc}, {27'h0, pc});
        check({tag, "_inst"}, out_inst, (pc == 5'd6) ? HALT : {27'h0, pc});
    endtask

    initial begin
        rst_n          = 1'b0;
        en             = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 5'd0;
        #12;
        check("rst_valid", {31'h0, out_valid}, 32'd0);
        check("rst_addr", {27'h0, adressIM}, 32'd0);
        check("rst_halted", {31'h0, halted}, 32'd0);
        check("rst_inst", out_inst, 32'd0);
        check("rst_outpc", {27'h0, out_pc}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Stream from reset up to and including the halt word.
        for (int k = 0; k <= 6; k++) begin
            step();
            check_slot($sformatf("seq%0d", k), 5'(k));
            check($sformatf("seq%0d_halted", k), {31'h0, halted}, (k == 6) ? 32'd1 : 32'd0);
        end
        for (int k = 0; k < 2; k++) begin
            step();
            check("halt_valid", {31'h0, out_valid}, 32'd0);
            check("halt_addr", {27'h0, adressIM}, 32'd7);
            check("halt_halted", {31'h0, halted}, 32'd1);
        end

        // Redirect out of HALT to 0.
        redirect_valid = 1'b1;
        redirect_pc    = 5'd0;
        step();
        redirect_valid = 1'b0;
        check("unhalt_halted", {31'h0, halted}, 32'd0);
        check("unhalt_valid", {31'h0, out_valid}, 32'd0);
        check("unhalt_addr", {27'h0, adressIM}, 32'd0);
        step();
        check_slot("resume0", 5'd0);
        step();
        check_slot("resume1", 5'd1);
        step();
        check_slot("resume2", 5'd2);

        // Back-pressure while out_pc == 2.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check_slot("stall", 5'd2);
            check("stall_addr", {27'h0, adressIM}, 32'd3);
        end
        out_ready = 1'b1;
        step();
        check_slot("unstall", 5'd3);
        check("unstall_addr", {27'h0, adressIM}, 32'd4);

        // Redirect to 17 while the slot is valid and being accepted.
        redirect_valid = 1'b1;
        redirect_pc    = 5'd17;
        step();
        redirect_valid = 1'b0;
        check("redir17_valid", {31'h0, out_valid}, 32'd0);
        check("redir17_addr", {27'h0, adressIM}, 32'd17);
        step();
        check_slot("redir17_a", 5'd17);
        step();
        check_slot("redir17_b", 5'd18);

        // Redirect to 30 and stream across the wrap.
        redirect_valid = 1'b1;
        redirect_pc    = 5'd30;
        step();
        redirect_valid = 1'b0;
        check("redir30_valid", {31'h0, out_valid}, 32'd0);
        step();
        check_slot("wrap30", 5'd30);
        step();
        check_slot("wrap31", 5'd31);
        step();
        check_slot("wrap0", 5'd0);
        step();
        check_slot("wrap1", 5'd1);

        // en low for two cycles: slot drains, PC frozen.
        en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            check("en0_valid", {31'h0, out_valid}, 32'd0);
            check("en0_addr", {27'h0, adressIM}, 32'd2);
        end
        en = 1'b1;
        step();
        check_slot("en1_a", 5'd2);
        step();
        check_slot("en1_b", 5'd3);

        // Asynchronous reset with pc == 4.
        check("prerst_addr", {27'h0, adressIM}, 32'd4);
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'h0, out_valid}, 32'd0);
        check("arst_addr", {27'h0, adressIM}, 32'd0);
        check("arst_halted", {31'h0, halted}, 32'd0);
        check("arst_outpc", {27'h0, out_pc}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_slot("restart0", 5'd0);
        step();
        check_slot("restart1", 5'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch sequencer that drives the instruction memory `SE`: it owns the program counter, presents it on `adressIM`, and captures the returned 32-bit `inst` into a registered output slot. The slot is handed to decode through a valid/ready handshake. The unit supports branch/jump redirects from execute and stops fetching after it captures a halt word. It sits between `SE` (combinational address-to-instruction lookup) and the decode stage.

## Interface
- `ADDR_W`, 5, width of PC and `adressIM` (32-entry instruction memory)
- `DATA_W`, 32, instruction width
- `RESET_PC`, 0, PC value after reset
- `HALT_WORD`, 32'hFFFF_FFFF, instruction encoding that stops fetching
- `clk`  in  1  system clock, rising-edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `en`  in  1  fetch enable; 0 freezes the PC and blocks capture
- `adressIM`  out  ADDR_W  address to `SE`; always equals the PC register
- `inst`  in  DATA_W  instruction from `SE`, combinational from `adressIM`
- `redirect_valid`  in  1  execute requests a PC change this cycle
- `redirect_pc`  in  ADDR_W  redirect target
- `out_valid`  out  1  output slot holds an instruction
- `out_ready`  in  1  decode accepts the slot this cycle
- `out_inst`  out  DATA_W  captured instruction
- `out_pc`  out  ADDR_W  address `out_inst` was fetched from
- `halted`  out  1  unit is in HALT state

## Operation
- Two states: RUN and HALT. `halted` is 1 exactly when the unit is in HALT.
- A transfer occurs when `out_valid && out_ready`.
- The slot is free when `!out_valid || out_ready`.
- fire = `en && state==RUN && !redirect_valid && slot free`.
- On fire, at the clock edge:
  - `out_inst <= inst` and `out_pc <= pc`.
  - `out_valid <= 1`.
  - `pc <= pc + 1`, modulo 2^ADDR_W, so 31 wraps to 0.
  - If `inst == HALT_WORD`, state goes to HALT. The halt word itself is still delivered in the slot.
- If a transfer occurs without fire, `out_valid <= 0`.
- If neither a transfer nor fire occurs, the slot holds. `out_inst` and `out_pc` stay stable while `out_valid && !out_ready`.
- Redirect has highest priority and ignores `en`. At the edge:
  - `pc <= redirect_pc`
  - `out_valid <= 0` (the slot is flushed, even if it was being accepted)
  - state goes to RUN (clears HALT)
- In HALT:
  - PC holds.
  - The slot drains normally through the handshake.
  - No new capture occurs until a redirect.
- `en=0`: PC and state hold; the slot still drains.
- No arithmetic other than the PC increment. The PC carry is discarded.

## Timing
- Reset values (asynchronous, while `rst_n=0`):
  - pc = `adressIM` = RESET_PC
  - `out_valid` = 0, `out_inst` = 0, `out_pc` = 0
  - state = RUN, `halted` = 0
- `adressIM` is a direct register output. `inst` must settle within the same cycle.
- Latency: the instruction at address A appears on `out_inst` in the cycle after the cycle in which pc==A.
- Throughput: one instruction per cycle while `out_ready=1`.
- Back-pressure:
  - With `out_valid=1` and `out_ready=0`, the PC does not advance.
  - The fetch resumes in the same cycle `out_ready` rises (no bubble).
- Redirect:
  - `out_valid` is 0 in the cycle after redirect.
  - The target instruction is valid two cycles after the redirect cycle.
- Halt: `halted` rises in the same edge that loads the halt word into the slot.
- Reset mid-operation: all state returns to reset values immediately, without waiting for a clock edge. The first fetch starts from RESET_PC after `rst_n` deasserts.

## Test plan
- Bench memory model: `SE` returns `{27'h0, addr}` for every address except address 6, which returns `HALT_WORD`.
- Reset, `en=1`, `out_ready=1` -> `out_pc` sequence 0,1,2,3,4,5,6 on consecutive cycles with `out_inst == out_pc`. At `out_pc=6`, `out_inst=32'hFFFF_FFFF` and `halted=1`. Afterwards `out_valid=0` and `adressIM` stays at 7.
- Stream with `out_ready` low for 3 cycles while `out_pc=2` -> `out_inst=2` held stable; `adressIM` stays at 3; the next transfer is `out_pc=3` with no gap after `out_ready` rises.
- `redirect_valid=1`, `redirect_pc=17` while `out_valid=1` -> `out_valid=0` next cycle, then `out_pc=17`, `out_inst=17`, then 18.
- Redirect to 30 then stream -> `out_pc` 30, 31, 0, 1 (wrap-around) with no stall.
- While halted, redirect to 0 -> `halted` drops on that edge; fetch resumes with `out_pc=0`.
- Assert `rst_n=0` mid-stream at `pc=4` -> immediately `out_valid=0`, `adressIM=0`, `halted=0`; after release, the sequence restarts at 0.
- `en=0` for 2 cycles mid-stream with `out_ready=1` -> the slot drains to `out_valid=0`, PC frozen; the sequence continues unchanged when `en` returns to 1.
